// File: rtl/handshake_seq_gen_if.sv
// Bundles the start command and req/busy/gnt handshake of handshake_seq_gen.
// The master drives the command side; the generator itself sits on the slave modport.
interface handshake_seq_gen_if #(
    parameter int CNT_W = 4,
    parameter int SEQ_W = 8
);
    logic             start;
    logic [CNT_W-1:0] busy_num;
    logic [CNT_W-1:0] gnt_gap;
    logic             ready;
    logic             req;
    logic             busy;
    logic             gnt;
    logic             done;
    logic [SEQ_W-1:0] seq_count;

    modport master (
        output start, busy_num, gnt_gap,
        input  ready, req, busy, gnt, done, seq_count
    );

    modport slave (
        input  start, busy_num, gnt_gap,
        output ready, req, busy, gnt, done, seq_count
    );
endinterface

// File: rtl/handshake_seq_gen.sv
// Generates one req pulse, n spaced single-cycle busy pulses and a gnt pulse g
// idle cycles after the last busy, for each start accepted while ready.
module handshake_seq_gen #(
    parameter int CNT_W = 4,
    parameter int SEQ_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    handshake_seq_gen_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP0,
        BUSY_HI,
        BUSY_LO,
        WAIT,
        GNT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             gnt_q, gnt_d;
    logic             done_q, done_d;

    // The cycle after the last busy (or after req when n=0) is the first gap
    // cycle itself, so WAIT lasts g cycles and g=0 lands gnt right there.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        seq_d   = seq_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcnt_d  = bus.busy_num;
                    gcnt_d  = bus.gnt_gap;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bcnt_q != '0)      state_d = GAP0;
                else if (gcnt_q != '0) state_d = WAIT;
                else                   state_d = GNT;
            end
            GAP0:    state_d = BUSY_HI;
            BUSY_HI: begin
                bcnt_d = bcnt_q - CNT_W'(1);
                if (bcnt_q != CNT_W'(1)) state_d = BUSY_LO;
                else if (gcnt_q != '0)   state_d = WAIT;
                else                     state_d = GNT;
            end
            BUSY_LO: state_d = BUSY_HI;
            WAIT: begin
                gcnt_d = gcnt_q - CNT_W'(1);
                if (gcnt_q == CNT_W'(1)) state_d = GNT;
            end
            GNT: begin
                seq_d   = seq_q + SEQ_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Output flops load from the next state so their levels track state_q exactly.
        req_d  = (state_d == REQ);
        busy_d = (state_d == BUSY_HI);
        gnt_d  = (state_d == GNT);
        done_d = (state_d == GNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            seq_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            seq_q   <= seq_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.req       = req_q;
    assign bus.busy      = busy_q;
    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.seq_count = seq_q;
endmodule
